axi_ic_w_router: RTL and testbench

//  Interconnect W-channel stage, directly downstream of the AW routing stage.

---
 rtl/axi_ic_w_router.sv | 150 +++++++++++++++
 tb/tb_axi_ic_w_router.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_ic_w_router.sv
// axi_ic_w_router: W-channel router for a small AXI interconnect.
// Per-master and per-slave FIFOs record the AW handshake order. A master's
// W burst reaches a slave only when the two FIFO heads name each other, so W
// data follows AW order on both sides. The last-beat handshake pops both
// heads and is echoed on wlast_hs_o to release the AW lock arbiters.
module axi_ic_w_router #(
  parameter int NumMasters = 2,
  parameter int NumSlaves  = 2,
  parameter int DataWidth  = 32,
  parameter int Depth      = 4,
  localparam int SelWidth  = (NumSlaves > 1) ? $clog2(NumSlaves) : 1,
  localparam int MstWidth  = (NumMasters > 1) ? $clog2(NumMasters) : 1,
  localparam int StrbWidth = DataWidth / 8
) (
  input  logic                                  aclk,
  input  logic                                  rst_n,
  input  logic [NumMasters-1:0]                 aw_hs_i,
  input  logic [NumMasters-1:0][SelWidth-1:0]   aw_sel_i,
  output logic [NumMasters-1:0]                 aw_stall_o,
  input  logic [NumMasters-1:0]                 m_wvalid_i,
  input  logic [NumMasters-1:0][DataWidth-1:0]  m_wdata_i,
  input  logic [NumMasters-1:0][StrbWidth-1:0]  m_wstrb_i,
  input  logic [NumMasters-1:0]                 m_wlast_i,
  output logic [NumMasters-1:0]                 m_wready_o,
  output logic [NumSlaves-1:0]                  s_wvalid_o,
  output logic [NumSlaves-1:0][DataWidth-1:0]   s_wdata_o,
  output logic [NumSlaves-1:0][StrbWidth-1:0]   s_wstrb_o,
  output logic [NumSlaves-1:0]                  s_wlast_o,
  input  logic [NumSlaves-1:0]                  s_wready_i,
  output logic [NumSlaves-1:0]                  wlast_hs_o
);

  localparam int AddrWidth = $clog2(Depth);
  localparam int PtrWidth  = AddrWidth + 1;

  // FIFO storage (data only, pointers carry the state)
  logic [SelWidth-1:0] mmem_q [NumMasters][Depth];
  logic [MstWidth-1:0] smem_q [NumSlaves][Depth];

  logic [NumMasters-1:0][PtrWidth-1:0] mwp_q, mwp_d, mrp_q, mrp_d;
  logic [NumSlaves-1:0][PtrWidth-1:0]  swp_q, swp_d, srp_q, srp_d;

  logic [NumMasters-1:0]               mempty, mfull, mpush, mpop;
  logic [NumMasters-1:0][SelWidth-1:0] mhead;
  logic [NumSlaves-1:0]                sempty, sfull, spush, spop;
  logic [NumSlaves-1:0][MstWidth-1:0]  shead, spush_mst;

  // FIFO status and head entries
  always_comb begin
    for (int unsigned m = 0; m < NumMasters; m++) begin
      mempty[m] = (mwp_q[m] == mrp_q[m]);
      mfull[m]  = (mwp_q[m][PtrWidth-1] != mrp_q[m][PtrWidth-1]) &&
                  (mwp_q[m][AddrWidth-1:0] == mrp_q[m][AddrWidth-1:0]);
      mhead[m]  = mmem_q[m][mrp_q[m][AddrWidth-1:0]];
    end
    for (int unsigned s = 0; s < NumSlaves; s++) begin
      sempty[s] = (swp_q[s] == srp_q[s]);
      sfull[s]  = (swp_q[s][PtrWidth-1] != srp_q[s][PtrWidth-1]) &&
                  (swp_q[s][AddrWidth-1:0] == srp_q[s][AddrWidth-1:0]);
      shead[s]  = smem_q[s][srp_q[s][AddrWidth-1:0]];
    end
  end

  // AW stall and FIFO push requests; pushes into a full FIFO are refused
  always_comb begin
    aw_stall_o = '0;
    spush      = '0;
    spush_mst  = '0;
    for (int unsigned m = 0; m < NumMasters; m++) begin
      aw_stall_o[m] = mfull[m];
      for (int unsigned s = 0; s < NumSlaves; s++) begin
        if (aw_sel_i[m] == SelWidth'(s)) begin
          if (sfull[s]) aw_stall_o[m] = 1'b1;
          if (aw_hs_i[m]) begin
            spush[s]     = ~sfull[s];
            spush_mst[s] = MstWidth'(m);
          end
        end
      end
    end
    mpush = aw_hs_i & ~mfull;
  end

  // W routing over open paths, last-beat pops and unlock pulses
  always_comb begin
    s_wvalid_o = '0;
    s_wdata_o  = '0;
    s_wstrb_o  = '0;
    s_wlast_o  = '0;
    m_wready_o = '0;
    spop       = '0;
    mpop       = '0;
    wlast_hs_o = '0;
    for (int unsigned s = 0; s < NumSlaves; s++) begin
      for (int unsigned m = 0; m < NumMasters; m++) begin
        if (!mempty[m] && (mhead[m] == SelWidth'(s)) &&
            !sempty[s] && (shead[s] == MstWidth'(m))) begin
          s_wvalid_o[s] = m_wvalid_i[m];
          s_wdata_o[s]  = m_wdata_i[m];
          s_wstrb_o[s]  = m_wstrb_i[m];
          s_wlast_o[s]  = m_wlast_i[m];
          m_wready_o[m] = s_wready_i[s];
        end
      end
      spop[s]       = s_wvalid_o[s] & s_wready_i[s] & s_wlast_o[s];
      wlast_hs_o[s] = spop[s];
      for (int unsigned m = 0; m < NumMasters; m++) begin
        if (spop[s] && (shead[s] == MstWidth'(m))) mpop[m] = 1'b1;
      end
    end
  end

  // Pointer next-state: push and pop may both happen in one cycle
  always_comb begin
    for (int unsigned m = 0; m < NumMasters; m++) begin
      mwp_d[m] = mwp_q[m] + PtrWidth'(mpush[m]);
      mrp_d[m] = mrp_q[m] + PtrWidth'(mpop[m]);
    end
    for (int unsigned s = 0; s < NumSlaves; s++) begin
      swp_d[s] = swp_q[s] + PtrWidth'(spush[s]);
      srp_d[s] = srp_q[s] + PtrWidth'(spop[s]);
    end
  end

  // Pointer registers; reset empties every FIFO and drops in-flight bursts
  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      mwp_q <= '0;
      mrp_q <= '0;
      swp_q <= '0;
      srp_q <= '0;
    end else begin
      mwp_q <= mwp_d;
      mrp_q <= mrp_d;
      swp_q <= swp_d;
      srp_q <= srp_d;
    end
  end

  // FIFO entry writes
  always_ff @(posedge aclk) begin
    for (int unsigned m = 0; m < NumMasters; m++) begin
      if (mpush[m]) mmem_q[m][mwp_q[m][AddrWidth-1:0]] <= aw_sel_i[m];
    end
    for (int unsigned s = 0; s < NumSlaves; s++) begin
      if (spush[s]) smem_q[s][swp_q[s][AddrWidth-1:0]] <= spush_mst[s];
    end
  end

endmodule

// File: tb/tb_axi_ic_w_router.sv
// tb_axi_ic_w_router: scoreboard bench for the W-channel router.
// Bursts are planned per master; an accepted AW appends that burst's beats to
// the target slave's expected queue. A monitor checks every slave-side beat,
// the unlock pulse, aw_stall_o against outstanding-AW counts, and idle outputs.
module tb_axi_ic_w_router;

  localparam int NM  = 2;
  localparam int NS  = 2;
  localparam int DW  = 32;
  localparam int SW  = DW / 8;
  localparam int DEP = 4;

  logic                   aclk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [NM-1:0]          aw_hs;
  logic [NM-1:0][0:0]     aw_sel;
  logic [NM-1:0]          aw_stall;
  logic [NM-1:0]          m_wvalid;
  logic [NM-1:0][DW-1:0]  m_wdata;
  logic [NM-1:0][SW-1:0]  m_wstrb;
  logic [NM-1:0]          m_wlast;
  logic [NM-1:0]          m_wready;
  logic [NS-1:0]          s_wvalid;
  logic [NS-1:0][DW-1:0]  s_wdata;
  logic [NS-1:0][SW-1:0]  s_wstrb;
  logic [NS-1:0]          s_wlast;
  logic [NS-1:0]          s_wready;
  logic [NS-1:0]          wlast_hs;

  always #5 aclk = ~aclk;

  axi_ic_w_router #(
    .NumMasters(NM),
    .NumSlaves (NS),
    .DataWidth (DW),
    .Depth     (DEP)
  ) dut (
    .aclk      (aclk),
    .rst_n     (rst_n),
    .aw_hs_i   (aw_hs),
    .aw_sel_i  (aw_sel),
    .aw_stall_o(aw_stall),
    .m_wvalid_i(m_wvalid),
    .m_wdata_i (m_wdata),
    .m_wstrb_i (m_wstrb),
    .m_wlast_i (m_wlast),
    .m_wready_o(m_wready),
    .s_wvalid_o(s_wvalid),
    .s_wdata_o (s_wdata),
    .s_wstrb_o (s_wstrb),
    .s_wlast_o (s_wlast),
    .s_wready_i(s_wready),
    .wlast_hs_o(wlast_hs)
  );

  typedef struct {
    int unsigned sel;
    int unsigned len;
    logic [DW-1:0] base;
    int unsigned aw_dly;
    int unsigned w_dly;
  } burst_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic          last;
    int unsigned   mst;
  } beat_t;

  burst_t awq  [NM][$];
  burst_t wq   [NM][$];
  beat_t  expq [NS][$];
  int mcnt [NM];
  int scnt [NS];
  int pending_bursts = 0;
  int s_beats = 0;
  int errors = 0;
  int checks = 0;
  int unsigned rdy_mode = 0;
  bit gap_mode = 1'b0;

  function automatic logic [DW-1:0] beat_data(input logic [DW-1:0] base, input int unsigned i);
    return base + DW'(i) * 32'h11;
  endfunction

  function automatic logic [SW-1:0] beat_strb(input logic [DW-1:0] base, input int unsigned i);
    return base[SW-1:0] ^ SW'(i);
  endfunction

  task automatic plan(input int unsigned m, input int unsigned s, input int unsigned len,
                      input logic [DW-1:0] base, input int unsigned awd, input int unsigned wd);
    burst_t b;
    b.sel = s; b.len = len; b.base = base; b.aw_dly = awd; b.w_dly = wd;
    awq[m].push_back(b);
    wq[m].push_back(b);
    pending_bursts++;
  endtask

  task automatic wait_idle(input int unsigned budget, input string name);
    int unsigned n = 0;
    while (pending_bursts != 0 && n < budget) begin
      @(posedge aclk);
      n++;
    end
    checks++;
    if (pending_bursts != 0) begin
      errors++;
      $display("FAIL %s_timeout: pending bursts=%0d required=0", name, pending_bursts);
    end
    repeat (3) @(posedge aclk);
  endtask

  // Stimulus driver: AW issue, master W beats, slave ready
  int awwait [NM];
  int wwait  [NM];
  bit wact   [NM];
  int unsigned wbeat [NM];
  bit w_acc  [NM];
  initial begin : drv
    burst_t b;
    beat_t e;
    bit [NM-1:0] cand;
    bit [NS-1:0] used;
    int unsigned rdy_ph;
    rdy_ph = 0;
    aw_hs = '0; aw_sel = '0; m_wvalid = '0; m_wdata = '0; m_wstrb = '0; m_wlast = '0;
    s_wready = '0;
    for (int m = 0; m < NM; m++) begin
      awwait[m] = -1; wwait[m] = -1; wact[m] = 1'b0; wbeat[m] = 0;
    end
    forever begin
      @(negedge aclk);
      for (int m = 0; m < NM; m++) w_acc[m] = m_wvalid[m] & m_wready[m];
      @(posedge aclk);
      #1;
      if (!rst_n) begin
        for (int m = 0; m < NM; m++) begin
          awq[m].delete(); wq[m].delete();
          awwait[m] = -1; wwait[m] = -1; wact[m] = 1'b0; wbeat[m] = 0; mcnt[m] = 0;
        end
        for (int s = 0; s < NS; s++) begin
          expq[s].delete(); scnt[s] = 0;
        end
        pending_bursts = 0;
        aw_hs = '0; m_wvalid = '0; m_wdata = '0; m_wstrb = '0; m_wlast = '0; s_wready = '0;
        rdy_ph = 0;
        continue;
      end
      // AW handshakes completed at the edge just passed
      for (int m = 0; m < NM; m++) begin
        if (aw_hs[m]) begin
          b = awq[m].pop_front();
          for (int unsigned i = 0; i < b.len; i++) begin
            e.data = beat_data(b.base, i);
            e.strb = beat_strb(b.base, i);
            e.last = (i == b.len - 1);
            e.mst  = m;
            expq[b.sel].push_back(e);
          end
          mcnt[m]++;
          scnt[b.sel]++;
          awwait[m] = -1;
        end
      end
      aw_hs = '0;
      cand = '0;
      for (int m = 0; m < NM; m++) begin
        if (awq[m].size() > 0) begin
          if (awwait[m] < 0) awwait[m] = int'(awq[m][0].aw_dly);
          if (awwait[m] == 0) begin
            cand[m] = 1'b1;
            aw_sel[m] = 1'(awq[m][0].sel);
          end else begin
            awwait[m]--;
          end
        end
      end
      // W beats
      for (int m = 0; m < NM; m++) begin
        if (wact[m] && w_acc[m]) begin
          wbeat[m]++;
          if (wbeat[m] == wq[m][0].len) begin
            void'(wq[m].pop_front());
            wact[m] = 1'b0;
            wwait[m] = -1;
          end
        end
        if (!wact[m] && wq[m].size() > 0) begin
          if (wwait[m] < 0) wwait[m] = int'(wq[m][0].w_dly);
          if (wwait[m] == 0) begin
            wact[m] = 1'b1;
            wbeat[m] = 0;
          end else begin
            wwait[m]--;
          end
        end
        if (wact[m]) begin
          if (!(m_wvalid[m] && !w_acc[m]))
            m_wvalid[m] = gap_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
          m_wdata[m] = beat_data(wq[m][0].base, wbeat[m]);
          m_wstrb[m] = beat_strb(wq[m][0].base, wbeat[m]);
          m_wlast[m] = (wbeat[m] == wq[m][0].len - 1);
        end else begin
          m_wvalid[m] = 1'b0; m_wdata[m] = '0; m_wstrb[m] = '0; m_wlast[m] = 1'b0;
        end
      end
      // Slave ready
      for (int s = 0; s < NS; s++) begin
        case (rdy_mode)
          1: s_wready[s] = ($urandom_range(0, 3) != 0);
          2: s_wready[s] = (s != 0) || (rdy_ph % 4 == 0) || (rdy_ph % 4 == 3);
          default: s_wready[s] = 1'b1;
        endcase
      end
      rdy_ph++;
      // AW issue, gated by stall and one push per slave
      #1;
      used = '0;
      for (int m = 0; m < NM; m++) begin
        if (cand[m] && !aw_stall[m] && !used[aw_sel[m]]) begin
          aw_hs[m] = 1'b1;
          used[aw_sel[m]] = 1'b1;
        end
      end
    end
  end

  // Monitor: compares DUT outputs against the scoreboard and counts model
  initial begin : mon
    beat_t e;
    bit exp_st;
    int unsigned npush;
    bit pend_s [NS];
    int unsigned pend_m [NS];
    forever begin
      @(negedge aclk);
      for (int s = 0; s < NS; s++) pend_s[s] = 1'b0;
      if (!rst_n) begin
        checks++;
        if ({s_wvalid, m_wready, wlast_hs, s_wdata, s_wstrb, s_wlast, aw_stall} !== '0) begin
          errors++;
          $display("FAIL reset_outputs: wvalid=%b wready=%b wlast_hs=%b wdata=%h wstrb=%h wlast=%b stall=%b required all 0",
                   s_wvalid, m_wready, wlast_hs, s_wdata, s_wstrb, s_wlast, aw_stall);
        end
      end else begin
        for (int m = 0; m < NM; m++) begin
          exp_st = (mcnt[m] >= DEP) || (scnt[aw_sel[m]] >= DEP);
          checks++;
          if (aw_stall[m] !== exp_st) begin
            errors++;
            $display("FAIL aw_stall[%0d]: got %b required %b (mcnt=%0d scnt=%0d)",
                     m, aw_stall[m], exp_st, mcnt[m], scnt[aw_sel[m]]);
          end
          if (mcnt[m] == 0) begin
            checks++;
            if (m_wready[m] !== 1'b0) begin
              errors++;
              $display("FAIL m_wready_idle[%0d]: got %b required 0", m, m_wready[m]);
            end
          end
        end
        for (int s = 0; s < NS; s++) begin
          npush = 0;
          for (int m = 0; m < NM; m++) if (aw_hs[m] && aw_sel[m] == 1'(s)) npush++;
          if (npush > 1) begin
            checks++; errors++;
            $display("FAIL aw_push_per_slave[%0d]: got %0d pushes required at most 1", s, npush);
          end
          if (scnt[s] == 0) begin
            checks++;
            if ({s_wvalid[s], s_wdata[s], s_wstrb[s], s_wlast[s]} !== '0) begin
              errors++;
              $display("FAIL s_idle[%0d]: valid=%b data=%h strb=%h last=%b required all 0",
                       s, s_wvalid[s], s_wdata[s], s_wstrb[s], s_wlast[s]);
            end
          end
          if (s_wvalid[s] && s_wready[s]) begin
            s_beats++;
            checks++;
            if (expq[s].size() == 0) begin
              errors++;
              $display("FAIL s_beat[%0d]: unexpected beat data=%h required no beat", s, s_wdata[s]);
            end else begin
              e = expq[s].pop_front();
              if (s_wdata[s] !== e.data || s_wstrb[s] !== e.strb || s_wlast[s] !== e.last ||
                  wlast_hs[s] !== e.last) begin
                errors++;
                $display("FAIL s_beat[%0d]: got data=%h strb=%h last=%b hs=%b required data=%h strb=%h last=%b hs=%b",
                         s, s_wdata[s], s_wstrb[s], s_wlast[s], wlast_hs[s], e.data, e.strb, e.last, e.last);
              end
              if (e.last) begin
                pend_s[s] = 1'b1;
                pend_m[s] = e.mst;
                pending_bursts--;
              end
            end
          end else begin
            checks++;
            if (wlast_hs[s] !== 1'b0) begin
              errors++;
              $display("FAIL wlast_hs_idle[%0d]: got %b required 0", s, wlast_hs[s]);
            end
          end
        end
      end
      @(posedge aclk);
      for (int s = 0; s < NS; s++) begin
        if (pend_s[s]) begin
          scnt[s]--;
          mcnt[pend_m[s]]--;
        end
      end
    end
  end

  // Test sequence
  initial begin : main
    bit seen11;
    int start;
    int unsigned n;
    repeat (3) @(posedge aclk);
    #3 rst_n = 1'b1;

    // single 4-beat burst M0 -> S1
    plan(0, 1, 4, 32'h11, 0, 0);
    wait_idle(200, "single");

    // ordering: M1 presents W before its AW and behind M0's burst to S0
    plan(0, 0, 2, 32'hA000_0100, 1, 3);
    plan(1, 0, 2, 32'hB000_0200, 3, 0);
    wait_idle(200, "ordering");

    // concurrent M0 -> S0 and M1 -> S1
    plan(0, 0, 2, 32'hC000_0300, 0, 0);
    plan(1, 1, 2, 32'hD000_0400, 0, 0);
    seen11 = 1'b0;
    n = 0;
    while (pending_bursts != 0 && n < 200) begin
      @(negedge aclk);
      if (wlast_hs == 2'b11) seen11 = 1'b1;
      n++;
    end
    checks++;
    if (!seen11) begin
      errors++;
      $display("FAIL concurrent_wlast: got no 2'b11 pulse required one");
    end
    wait_idle(200, "concurrent");

    // backpressure on S0
    rdy_mode = 2;
    plan(0, 0, 4, 32'hE000_0500, 0, 0);
    wait_idle(200, "backpressure");
    rdy_mode = 0;

    // full: four AWs to S0 before any W
    plan(0, 0, 2, 32'h1000_0600, 0, 12);
    plan(0, 0, 2, 32'h2000_0700, 0, 0);
    plan(0, 0, 2, 32'h3000_0800, 0, 0);
    plan(0, 0, 2, 32'h4000_0900, 0, 0);
    n = 0;
    do begin @(negedge aclk); #1; n++; end while (mcnt[0] < DEP && n < 100);
    checks++;
    if (aw_stall[0] !== 1'b1) begin
      errors++;
      $display("FAIL full_stall: got %b required 1", aw_stall[0]);
    end
    n = 0;
    do begin @(negedge aclk); #1; n++; end while (pending_bursts > 3 && n < 100);
    @(posedge aclk);
    @(negedge aclk);
    #1;
    checks++;
    if (aw_stall[0] !== 1'b0) begin
      errors++;
      $display("FAIL full_release: got %b required 0", aw_stall[0]);
    end
    wait_idle(300, "full");

    // reset after beat 2 of 4, then a fresh burst
    plan(0, 0, 4, 32'h5000_0A00, 0, 0);
    start = s_beats;
    n = 0;
    while (s_beats < start + 2 && n < 100) begin
      @(posedge aclk);
      n++;
    end
    #3 rst_n = 1'b0;
    repeat (2) @(posedge aclk);
    #3 rst_n = 1'b1;
    plan(0, 0, 4, 32'h6000_0B00, 0, 0);
    wait_idle(200, "after_reset");

    // randomized traffic
    rdy_mode = 1;
    gap_mode = 1'b1;
    for (int m = 0; m < NM; m++) begin
      for (int k = 0; k < 30; k++) begin
        plan(m, $urandom_range(0, NS - 1), $urandom_range(1, 4), $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3));
      end
    end
    wait_idle(20000, "random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
